audio_i2s_tx: RTL

Serializes the final stereo mix onto a standard Philips I2S link for an external DAC. Sits directly downstream of the stereo summing mixer: it accepts one 16-bit left/right sample pair per frame through a valid/ready handshake, holds it in a one-entry buffer, and shifts it out MSB-first. It generates its own BCLK and LRCK from `clk`.

---
 rtl/genmidi_audio_pkg.sv | 21 ++
 rtl/i2s_clk_div.sv | 36 +++
 rtl/audio_i2s_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/genmidi_audio_pkg.sv
// Shared audio types and constants for the mixer and the I2S transmitter.
package genmidi_audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int I2S_SLOTS = 32;
  localparam int SLOT_W    = $clog2(I2S_SLOTS);

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  function automatic stereo_sample_t make_pair(input logic [SAMPLE_W-1:0] l,
                                               input logic [SAMPLE_W-1:0] r);
    stereo_sample_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK generator: divides clk by 2*BCLK_DIV and flags the clk edge on which
// BCLK is about to fall, so downstream logic updates on that same edge.
module i2s_clk_div #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic o_bclk,
  output logic o_fall
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_bclk;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(BCLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_bclk = r_bclk;
  // High during the clk whose closing edge drives BCLK 1->0.
  assign o_fall = w_wrap & r_bclk;

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: one-entry sample buffer with valid/ready intake,
// 32-slot frame shifter, and underrun repeat of the last transmitted pair.
module audio_i2s_tx
  import genmidi_audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] l_in,
  input  logic [SAMPLE_W-1:0] r_in,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                underrun
);

  logic                  w_fall;
  logic                  w_load;
  logic                  w_accept;
  logic [SLOT_W-1:0]     w_slot_next;

  logic [SLOT_W-1:0]     r_slot;
  logic                  r_lrck;
  logic [2*SAMPLE_W-1:0] r_shift;
  stereo_sample_t        r_buf;
  stereo_sample_t        r_last;
  logic                  r_buf_full;
  logic                  r_underrun;

  i2s_clk_div #(.BCLK_DIV(BCLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .o_bclk  (i2s_bclk),
    .o_fall  (w_fall)
  );

  assign w_slot_next = r_slot + SLOT_W'(1);
  // The new word enters the shifter as slot 0 ends, giving the one-BCLK I2S delay.
  assign w_load      = w_fall && (r_slot == '0);
  assign w_accept    = s_valid && !r_buf_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot  <= '0;
      r_lrck  <= 1'b0;
      r_shift <= '0;
    end else if (w_fall) begin
      r_slot <= w_slot_next;
      r_lrck <= (w_slot_next >= SLOT_W'(SAMPLE_W));
      if (w_load) begin
        r_shift <= r_buf_full ? r_buf : r_last;
      end else begin
        r_shift <= {r_shift[2*SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  // An accept coinciding with an empty-buffer load is kept for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf      <= '0;
      r_last     <= '0;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_buf_full;
      if (w_load && r_buf_full) begin
        r_last     <= r_buf;
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf      <= make_pair(l_in, r_in);
        r_buf_full <= 1'b1;
      end
    end
  end

  assign s_ready   = ~r_buf_full;
  assign i2s_lrck  = r_lrck;
  assign i2s_sdata = r_shift[2*SAMPLE_W-1];
  assign underrun  = r_underrun;

endmodule
